// File: rtl/encoder_pkg.sv
// Shared sizes and index helpers for the 4-to-2 pending request encoder.
package encoder_pkg;

   localparam int N_REQ  = 4;
   localparam int W_CODE = $clog2(N_REQ);

   function automatic logic [N_REQ-1:0] onehot_f(input logic [W_CODE-1:0] idx);
      onehot_f      = '0;
      onehot_f[idx] = 1'b1;
   endfunction

   // Returns 0 for an all-zero vector; callers gate on |vec where that matters.
   function automatic logic [W_CODE-1:0] lowest_idx_f(input logic [N_REQ-1:0] vec);
      lowest_idx_f = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            lowest_idx_f = W_CODE'(i);
         end
      end
   endfunction

endpackage

// File: rtl/encoder_4to2_pending_rr_pick.sv
// Combinational picker: first set bit at or after last+1, wrapping; last=N-1 gives fixed priority.
module rr_pick
   import encoder_pkg::*;
#(
   parameter int N = N_REQ,
   parameter int W = W_CODE
) (
   input  logic [N-1:0] vec_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] idx_o
);

   logic [W-1:0] start_s;
   logic [N-1:0] rot_s;
   logic [W-1:0] rot_idx_s;

   assign start_s = last_i + W'(1'b1);

   // Index arithmetic is W bits wide, so the rotation wraps mod N for free.
   for (genvar g = 0; g < N; g++) begin : g_rot
      assign rot_s[g] = vec_i[W'(g) + start_s];
   end

   always_comb begin
      rot_idx_s = lowest_idx_f(rot_s);
      if (|vec_i) begin
         idx_o = rot_idx_s + start_s;
      end else begin
         idx_o = '0;
      end
   end

endmodule

// File: rtl/encoder_4to2_pending.sv
// Latches request lines into a pending register and drains them one encoded index per ready cycle.
module encoder_4to2_pending
   import encoder_pkg::*;
#(
   parameter int N  = N_REQ,
   parameter int W  = W_CODE,
   parameter bit RR = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] din,
   input  logic         ready,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic [N-1:0] pending,
   output logic         dup_err
);

   localparam logic [W-1:0] LAST_MAX = W'(N - 1);

   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] last_q, last_d;
   logic         dup_q, dup_d;
   logic [W-1:0] pick_last_s;
   logic [W-1:0] pick_idx_s;
   logic         fire_s;
   logic [N-1:0] clear_s;
   logic [N-1:0] set_s;

   assign pick_last_s = RR ? last_q : LAST_MAX;

   rr_pick #(.N(N), .W(W)) u_pick (
      .vec_i  (pending_q),
      .last_i (pick_last_s),
      .idx_o  (pick_idx_s)
   );

   assign dout    = pick_idx_s;
   assign valid   = |pending_q;
   assign pending = pending_q;
   assign dup_err = dup_q;

   // Set has priority over clear so a re-request on the consumed line stays pending.
   always_comb begin
      fire_s    = valid & ready;
      clear_s   = fire_s ? onehot_f(pick_idx_s) : {N{1'b0}};
      set_s     = en ? din : {N{1'b0}};
      pending_d = (pending_q & ~clear_s) | set_s;
      dup_d     = en & (|(din & pending_q & ~clear_s));
      if (RR && fire_s) begin
         last_d = pick_idx_s;
      end else begin
         last_d = last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         last_q    <= LAST_MAX;
         dup_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         last_q    <= last_d;
         dup_q     <= dup_d;
      end
   end

endmodule

// File: tb/tb_encoder_4to2_pending.sv
// Directed-vector bench for encoder_4to2_pending in round-robin mode.
module tb_encoder_4to2_pending;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] din;
   logic       ready;
   logic [1:0] dout;
   logic       valid;
   logic [3:0] pending;
   logic       dup_err;

   int checks   = 0;
   int failures = 0;

   encoder_4to2_pending #(.N(4), .W(2), .RR(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .din     (din),
      .ready   (ready),
      .dout    (dout),
      .valid   (valid),
      .pending (pending),
      .dup_err (dup_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; din = 4'b0000; ready = 1'b0;
      step(); step();
      rst = 1'b0;
      check_val("rst_valid", 32'(valid), 32'd0);
      check_val("rst_dout", 32'(dout), 32'd0);
      check_val("rst_pending", 32'(pending), 32'd0);
      check_val("rst_dup", 32'(dup_err), 32'd0);

      // T1 single request
      en = 1'b1; ready = 1'b1; din = 4'b0100;
      step(); din = 4'b0000;
      check_val("t1_valid", 32'(valid), 32'd1);
      check_val("t1_dout", 32'(dout), 32'd2);
      step();
      check_val("t1_valid_drop", 32'(valid), 32'd0);
      check_val("t1_pending", 32'(pending), 32'd0);

      // T2 round-robin drain from a fresh last=3
      rst = 1'b1; step(); rst = 1'b0;
      din = 4'b1111;
      step(); din = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("t2_dout%0d", i), 32'(dout), 32'(i));
         step();
      end
      check_val("t2_empty", 32'(valid), 32'd0);
      din = 4'b0011;
      step(); din = 4'b0000;
      check_val("t2_wrap0", 32'(dout), 32'd0);
      step();
      check_val("t2_wrap1", 32'(dout), 32'd1);
      step();
      check_val("t2_wrap_empty", 32'(valid), 32'd0);

      // T3 backpressure
      ready = 1'b0; din = 4'b0010;
      step(); din = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("t3_hold_v%0d", i), 32'(valid), 32'd1);
         check_val($sformatf("t3_hold_d%0d", i), 32'(dout), 32'd1);
         step();
      end
      ready = 1'b1;
      step();
      check_val("t3_release", 32'(valid), 32'd0);

      // T4 enable gating
      en = 1'b0; din = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val($sformatf("t4_gated_v%0d", i), 32'(valid), 32'd0);
         check_val($sformatf("t4_gated_p%0d", i), 32'(pending), 32'd0);
      end
      en = 1'b1;
      step(); din = 4'b0000;
      check_val("t4_dout", 32'(dout), 32'd3);
      step();
      check_val("t4_drained", 32'(valid), 32'd0);

      // T5a duplicate while stalled
      ready = 1'b0; din = 4'b0010;
      step();
      check_val("t5a_first_dup", 32'(dup_err), 32'd0);
      step(); din = 4'b0000;
      check_val("t5a_dup", 32'(dup_err), 32'd1);
      check_val("t5a_pending", 32'(pending), 32'd2);
      step();
      check_val("t5a_dup_pulse", 32'(dup_err), 32'd0);
      check_val("t5a_grant", 32'(dout), 32'd1);
      ready = 1'b1;
      step();
      check_val("t5a_single_grant", 32'(valid), 32'd0);
      step();
      check_val("t5a_still_empty", 32'(valid), 32'd0);

      // T5b set-over-clear on the line being consumed
      ready = 1'b0; din = 4'b0010;
      step(); din = 4'b0000;
      ready = 1'b1; din = 4'b0010;
      step(); din = 4'b0000;
      check_val("t5b_pending", 32'(pending), 32'd2);
      check_val("t5b_no_dup", 32'(dup_err), 32'd0);
      step();
      check_val("t5b_drained", 32'(valid), 32'd0);

      // T6 reset mid-drain, with requests asserted during reset
      ready = 1'b0; din = 4'b1011;
      step(); din = 4'b0000;
      check_val("t6_loaded", 32'(pending), 32'hb);
      rst = 1'b1; din = 4'b1111;
      step(); rst = 1'b0; din = 4'b0000;
      check_val("t6_valid", 32'(valid), 32'd0);
      check_val("t6_dout", 32'(dout), 32'd0);
      check_val("t6_pending", 32'(pending), 32'd0);
      check_val("t6_dup", 32'(dup_err), 32'd0);
      ready = 1'b1; din = 4'b1001;
      step(); din = 4'b0000;
      check_val("t6_first", 32'(dout), 32'd0);
      step();
      check_val("t6_second", 32'(dout), 32'd3);
      step();
      check_val("t6_empty", 32'(valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
